// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then clocks out
// one command byte under device clock. Optional PS2_TX_RETRY_EN re-sends on failure.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 100,
    parameter int START_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 100000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       send_valid,
    input  logic [7:0] send_data,
    output logic       send_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int MAX_AB  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int MAX_CD  = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int ATT_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST   = CNT_W'(RTS_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT - 1);
    localparam logic [ATT_W-1:0] ATT_MAX    = ATT_W'(MAX_RETRIES);

    localparam logic [1:0] ERR_START = 2'd1;
    localparam logic [1:0] ERR_BIT   = 2'd2;
    localparam logic [1:0] ERR_NOACK = 2'd3;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, WAIT_FIRST, BITS, ACK, RELEASE_OK, FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [9:0]       frame_q, frame_d;
    logic             dat_oe_q, dat_oe_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [ATT_W-1:0] attempts_q, attempts_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic fe;

    // Synchronisers reset to the idle-high bus level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            dat_oe_q   <= 1'b0;
            err_code_q <= 2'd0;
            attempts_q <= '0;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            dat_oe_q   <= dat_oe_d;
            err_code_q <= err_code_d;
            attempts_q <= attempts_d;
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign fe = clk_prev_q & ~clk_sync_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        frame_d    = frame_q;
        dat_oe_d   = dat_oe_q;
        err_code_d = err_code_q;
        attempts_d = attempts_q;
        done       = 1'b0;
        error      = 1'b0;

        case (state_q)
            IDLE: begin
                dat_oe_d = 1'b0;
                if (send_valid) begin
                    frame_d    = {1'b1, ~^send_data, send_data};
                    err_code_d = 2'd0;
                    attempts_d = '0;
                    cnt_d      = '0;
                    state_d    = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RTS: begin
                if (cnt_q == RTS_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_FIRST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The first device edge already asks for data bit 0.
            WAIT_FIRST: begin
                if (fe) begin
                    cnt_d     = '0;
                    dat_oe_d  = ~frame_q[0];
                    bit_idx_d = 4'd1;
                    state_d   = BITS;
                end else if (cnt_q == START_LAST) begin
                    dat_oe_d   = 1'b0;
                    err_code_d = ERR_START;
                    state_d    = FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BITS: begin
                if (fe) begin
                    cnt_d    = '0;
                    dat_oe_d = ~frame_q[bit_idx_q];
                    if (bit_idx_q == 4'd9) begin
                        state_d = ACK;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    dat_oe_d   = 1'b0;
                    err_code_d = ERR_BIT;
                    state_d    = FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: begin
                if (fe) begin
                    cnt_d = '0;
                    if (!dat_sync_q) begin
                        state_d = RELEASE_OK;
                    end else begin
                        err_code_d = ERR_NOACK;
                        state_d    = FAIL;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    err_code_d = ERR_BIT;
                    state_d    = FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE_OK: begin
                if (clk_sync_q && dat_sync_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == BIT_LAST) begin
                    err_code_d = ERR_BIT;
                    state_d    = FAIL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAIL: begin
                dat_oe_d = 1'b0;
                if (RETRY_EN && (attempts_q < ATT_MAX)) begin
                    attempts_d = attempts_q + 1'b1;
                    cnt_d      = '0;
                    state_d    = INHIBIT;
                end else begin
                    error   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe = (state_q == INHIBIT) || (state_q == RTS);
    assign ps2_dat_oe = dat_oe_q;
    assign send_ready = (state_q == IDLE);
    assign busy       = ~send_ready;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and randomized bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH = 8;
    localparam int RTS = 4;
    localparam int ST  = 200;
    localparam int BT  = 100;
`ifdef PS2_TX_RETRY_EN
    localparam int EXP_ATT = 3;
`else
    localparam int EXP_ATT = 1;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       send_valid = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       send_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
    logic [1:0] err_code;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       bus_clk, bus_dat;

    assign bus_clk = ps2_clk_oe ? 1'b0 : dev_clk;
    assign bus_dat = ps2_dat_oe ? 1'b0 : dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .START_TIMEOUT (ST),
        .BIT_TIMEOUT   (BT),
        .MAX_RETRIES   (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .send_valid(send_valid),
        .send_data (send_data),
        .send_ready(send_ready),
        .ps2_clk_in(bus_clk),
        .ps2_dat_in(bus_dat),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int   errs = 0;
    int   checks = 0;
    int   n_done, n_err, n_restart, n_both;
    logic last_clk_oe = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (done) n_done++;
        if (error) n_err++;
        if (done && error) n_both++;
        if (ps2_clk_oe && !last_clk_oe) n_restart++;
        last_clk_oe = ps2_clk_oe;
    endtask

    // Frame as the device must see it, LSB first: data, odd parity, stop.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    // mode 0: device ACKs; 1: device never clocks; 2: device stops after 4 edges; 3: no ACK.
    task automatic send_byte(input logic [7:0] b, input int mode, input bit inject);
        logic [9:0] expf;
        logic [9:0] samp;
        int         n;
        int         att_total;
        int         npulse;
        expf      = ref_frame(b);
        samp      = '0;
        att_total = (mode == 0) ? 1 : EXP_ATT;
        npulse    = (mode == 2) ? 4 : 11;

        chk("ready_before", send_ready, 1);
        send_data  = b;
        send_valid = 1'b1;
        tick();
        send_valid = 1'b0;
        send_data  = 8'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", send_ready, 0);
        chk("err_code_cleared", err_code, 0);

        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 100) begin n++; tick(); end
        chk("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk_oe && ps2_dat_oe && n < 100) begin n++; tick(); end
        chk("rts_len", n, RTS);

        for (int a = 0; a < att_total; a++) begin
            if (a > 0) begin
                n = 0;
                while (!(!ps2_clk_oe && ps2_dat_oe) && n < 500) begin n++; tick(); end
                chk("retry_restart_shape", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
            end else begin
                chk("release_shape", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
            end
            n_done = 0; n_err = 0; n_restart = 0; n_both = 0;
            last_clk_oe = ps2_clk_oe;

            if (mode == 1) begin
                n = 0;
                while (!error && !ps2_clk_oe && n < 400) begin n++; tick(); end
                if (a == att_total - 1) begin
                    chk("start_timeout_at", n, ST);
                    chk("start_err_pulse", error, 1);
                    chk("start_err_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
                end else begin
                    chk("start_retry_at", n, ST + 1);
                end
            end else begin
                repeat (30) tick();
                for (int p = 0; p < npulse; p++) begin
                    dev_clk = 1'b0;
                    if (inject && p == 2) begin send_data = 8'h00; send_valid = 1'b1; end
                    if (inject && p == 6) send_valid = 1'b0;
                    repeat (10) tick();
                    if (p < 10) samp[p] = bus_dat;
                    dev_clk = 1'b1;
                    repeat (5) tick();
                    if (p == 9 && mode == 0) dev_dat = 1'b0;
                    repeat (5) tick();
                    if (p == 10) dev_dat = 1'b1;
                end
                n = 0;
                while (n_done == 0 && n_err == 0 && n_restart == 0 && n < 400) begin n++; tick(); end
            end
            if (a < att_total - 1) begin
                chk("no_error_on_retry", n_err, 0);
                chk("retry_restarted", n_restart, 1);
            end
        end

        if (mode == 0) begin
            chk("done_pulse", done, 1);
            chk("busy_during_done", busy, 1);
            tick();
            chk("ready_after_done", send_ready, 1);
            repeat (3) tick();
            chk("done_count", n_done, 1);
            chk("no_error_on_ok", n_err, 0);
            chk("err_code_ok", err_code, 0);
            chk("frame_bits", samp, expf);
        end else begin
            chk("oe_released_at_fail", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
            tick();
            chk("ready_after_error", send_ready, 1);
            repeat (3) tick();
            chk("error_count", n_err, 1);
            chk("no_done_on_fail", n_done, 0);
            chk("err_code_fail", err_code, mode);
            if (mode == 3) chk("frame_bits_nack", samp, expf);
        end
        chk("done_error_exclusive", n_both, 0);
    endtask

    initial begin
        logic [7:0] rb;
        int         n;
        resetn = 1'b0;
        repeat (3) tick();
        chk("rst_ready", send_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        resetn = 1'b1;
        repeat (3) tick();

        send_byte(8'hF4, 0, 1'b0);
        send_byte(8'hFF, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(1, 255));
            send_byte(rb, 0, (i == 1));
        end
        send_byte(8'($urandom), 1, 1'b0);
        send_byte(8'($urandom), 2, 1'b0);
        send_byte(8'($urandom), 3, 1'b0);

        // Reset while the host is driving a data bit.
        send_data  = 8'h00;
        send_valid = 1'b1;
        tick();
        send_valid = 1'b0;
        n = 0;
        while (!(!ps2_clk_oe && ps2_dat_oe) && n < 100) begin n++; tick(); end
        repeat (30) tick();
        for (int p = 0; p < 4; p++) begin
            dev_clk = 1'b0;
            repeat (10) tick();
            dev_clk = 1'b1;
            repeat (10) tick();
        end
        chk("bits_dat_oe_before_reset", ps2_dat_oe, 1);
        n_done = 0; n_err = 0;
        resetn = 1'b0;
        tick();
        chk("midreset_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("midreset_ready", send_ready, 1);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (5) tick();
        chk("midreset_no_pulse", n_done + n_err, 0);

        send_byte(8'($urandom), 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #50ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
